// File: rtl/memoria_cache_pkg.sv
// Shared types and derived-width helpers for the parametrised write-back cache.
package memoria_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam int STAT_W = 16;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - $clog2(sets);
    endfunction

    function automatic int way_w(input int ways);
        return $clog2(ways);
    endfunction

    // Out of reset every set starts with way w at age w, so the top way is LRU.
    function automatic int reset_age(input int way);
        return way;
    endfunction

endpackage

// File: rtl/memoria_cache_lru.sv
// True-LRU age update plus victim / LRU-way selection for one set.
module memoria_cache_lru
    import memoria_cache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [WAYS*way_w(WAYS)-1:0] age_i,
    input  logic [WAYS-1:0]             valid_i,
    input  logic [way_w(WAYS)-1:0]      acc_way_i,
    output logic [WAYS*way_w(WAYS)-1:0] age_o,
    output logic [way_w(WAYS)-1:0]      victim_o,
    output logic [way_w(WAYS)-1:0]      lru_o
);

    localparam int WAY_W = way_w(WAYS);
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] acc_age_s;

    assign acc_age_s = age_i[acc_way_i*WAY_W +: WAY_W];

    // Ages younger than the accessed way move one step older; accessed way becomes youngest.
    always_comb begin
        age_o = age_i;
        for (int w = 0; w < WAYS; w++) begin
            age_o[w*WAY_W +: WAY_W] = (WAY_W'(w) == acc_way_i) ? WAY_W'(0) :
                (age_i[w*WAY_W +: WAY_W] < acc_age_s) ? age_i[w*WAY_W +: WAY_W] + WAY_W'(1) :
                age_i[w*WAY_W +: WAY_W];
        end
    end

    // Victim: lowest-index invalid way wins over the oldest way.
    always_comb begin
        victim_o = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            victim_o = (age_i[w*WAY_W +: WAY_W] == OLDEST) ? WAY_W'(w) : victim_o;
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            victim_o = !valid_i[w] ? WAY_W'(w) : victim_o;
        end
    end

    // LRU way reported after the update.
    always_comb begin
        lru_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            lru_o = (age_o[w*WAY_W +: WAY_W] == OLDEST) ? WAY_W'(w) : lru_o;
        end
    end

endmodule

// File: rtl/memoria_cache_param.sv
// N-way set-associative write-back cache, one word per line, with miss FSM.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module memoria_cache_param
    import memoria_cache_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 5,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req,
    input  logic                            wren,
    input  logic [DATA_W-1:0]               data,
    input  logic [ADDR_W-1:0]               address,
    output logic                            ready,
    output logic                            hit,
    output logic                            valid,
    output logic [way_w(WAYS)-1:0]          LRU,
    output logic                            dirty,
    output logic                            writeBack,
    output logic [tag_w(ADDR_W, SETS)-1:0]  tag,
    output logic [DATA_W-1:0]               dadoParaCPU,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]               hitCount,
    output logic [STAT_W-1:0]               missCount
`endif
);

    localparam int INDEX_W = index_w(SETS);
    localparam int TAG_W   = tag_w(ADDR_W, SETS);
    localparam int WAY_W   = way_w(WAYS);
    localparam int AGE_W   = WAYS * WAY_W;

    state_t              state_q;
    logic                wren_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WAY_W-1:0]    way_q;
    logic                wb_q;

    logic [WAYS-1:0]     valid_q    [SETS];
    logic [WAYS-1:0]     dirty_q    [SETS];
    logic [AGE_W-1:0]    age_q      [SETS];
    logic [DATA_W-1:0]   data_mem_q [SETS][WAYS];
    logic [TAG_W-1:0]    tag_mem_q  [SETS][WAYS];

    logic                ready_q, hit_q, valid_out_q, dirty_out_q, wb_out_q;
    logic [WAY_W-1:0]    lru_q;
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   dado_q;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0]   hit_cnt_q, miss_cnt_q;
`endif

    logic [INDEX_W-1:0]  idx_in_s, idx_lat_s, set_s;
    logic [TAG_W-1:0]    tag_in_s, tag_lat_s, arr_tag_s;
    logic [WAYS-1:0]     hit_vec_s;
    logic                hit_s, req_fire_s, victim_dirty_s, mem_done_s;
    logic                arr_we_s, done_s, new_dirty_s;
    logic [WAY_W-1:0]    hit_way_s, victim_s, acc_way_s, lru_new_s;
    logic [AGE_W-1:0]    age_new_s;
    logic [DATA_W-1:0]   arr_data_s, resp_data_s;

    assign idx_in_s  = address[INDEX_W-1:0];
    assign tag_in_s  = address[ADDR_W-1:INDEX_W];
    assign idx_lat_s = addr_q[INDEX_W-1:0];
    assign tag_lat_s = addr_q[ADDR_W-1:INDEX_W];

    // Tag compare against every way of the requested set.
    always_comb begin
        hit_vec_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_q[idx_in_s][w] && (tag_mem_q[idx_in_s][w] == tag_in_s);
        end
    end

    // Encode the matching way (at most one way can match).
    always_comb begin
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_way_s = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
        end
    end

    assign hit_s          = |hit_vec_s;
    assign set_s          = (state_q == IDLE) ? idx_in_s : idx_lat_s;
    assign acc_way_s      = (state_q == IDLE) ? (hit_s ? hit_way_s : victim_s) : way_q;
    assign req_fire_s     = (state_q == IDLE) && req;
    assign victim_dirty_s = valid_q[idx_in_s][victim_s] && dirty_q[idx_in_s][victim_s];
    assign mem_done_s     = mem_req_q && mem_ack;

    // A write miss with a clean victim installs at once since a line is one word.
    assign arr_we_s = (req_fire_s && wren && (hit_s || !victim_dirty_s)) ||
                      ((state_q == WRITEBACK) && mem_done_s && wren_q) ||
                      ((state_q == FILL) && mem_done_s);
    assign done_s      = arr_we_s || (req_fire_s && hit_s);
    assign arr_data_s  = (state_q == FILL) ? mem_rdata : ((state_q == IDLE) ? data : data_q);
    assign arr_tag_s   = (state_q == IDLE) ? tag_in_s : tag_lat_s;
    assign new_dirty_s = arr_we_s ? (state_q != FILL) : dirty_q[set_s][acc_way_s];
    assign resp_data_s = arr_we_s ? arr_data_s : data_mem_q[set_s][acc_way_s];

    memoria_cache_lru #(.WAYS(WAYS)) u_lru (
        .age_i     (age_q[set_s]),
        .valid_i   (valid_q[set_s]),
        .acc_way_i (acc_way_s),
        .age_o     (age_new_s),
        .victim_o  (victim_s),
        .lru_o     (lru_new_s)
    );

    // Data and tag storage; contents are undefined until written.
    always_ff @(posedge clock) begin
        if (arr_we_s && !reset) begin
            data_mem_q[set_s][acc_way_s] <= arr_data_s;
            tag_mem_q[set_s][acc_way_s]  <= arr_tag_s;
        end
    end

    // Miss FSM, line state bits, LRU ages and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wren_q      <= 1'b0;
            data_q      <= '0;
            addr_q      <= '0;
            way_q       <= '0;
            wb_q        <= 1'b0;
            ready_q     <= 1'b0;
            hit_q       <= 1'b0;
            valid_out_q <= 1'b0;
            dirty_out_q <= 1'b0;
            wb_out_q    <= 1'b0;
            lru_q       <= '0;
            tag_q       <= '0;
            dado_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w*WAY_W +: WAY_W] <= WAY_W'(reset_age(w));
                end
            end
`ifdef CACHE_STATS_EN
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
`endif
        end else if (done_s) begin
            valid_q[set_s][acc_way_s] <= 1'b1;
            dirty_q[set_s][acc_way_s] <= new_dirty_s;
            age_q[set_s]              <= age_new_s;
            ready_q     <= 1'b1;
            hit_q       <= (state_q == IDLE) && hit_s;
            valid_out_q <= 1'b1;
            dirty_out_q <= new_dirty_s;
            wb_out_q    <= (state_q != IDLE) && wb_q;
            lru_q       <= lru_new_s;
            tag_q       <= arr_tag_s;
            dado_q      <= resp_data_s;
            mem_req_q   <= 1'b0;
            state_q     <= RESP;
`ifdef CACHE_STATS_EN
            if ((state_q == IDLE) && hit_s) begin
                hit_cnt_q <= (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
            end else begin
                miss_cnt_q <= (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
            end
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wren_q      <= wren;
                        data_q      <= data;
                        addr_q      <= address;
                        way_q       <= acc_way_s;
                        wb_q        <= victim_dirty_s;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= victim_dirty_s;
                        mem_addr_q  <= victim_dirty_s ? {tag_mem_q[idx_in_s][victim_s], idx_in_s} : address;
                        mem_wdata_q <= data_mem_q[idx_in_s][victim_s];
                        state_q     <= victim_dirty_s ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    // A read still needs its fill; mem_req stays low for one cycle between phases.
                    if (mem_done_s) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= addr_q;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = ready_q;
    assign hit         = hit_q;
    assign valid       = valid_out_q;
    assign LRU         = lru_q;
    assign dirty       = dirty_out_q;
    assign writeBack   = wb_out_q;
    assign tag         = tag_q;
    assign dadoParaCPU = dado_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
`ifdef CACHE_STATS_EN
    assign hitCount    = hit_cnt_q;
    assign missCount   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_memoria_cache_param.sv
// Scoreboard bench for memoria_cache_param with default parameters and a simple memory model.
module tb_memoria_cache_param;

    logic       clock = 1'b0;
    logic       reset, req, wren, mem_ack;
    logic [2:0] data, mem_rdata;
    logic [4:0] address;
    logic       ready, hit, valid, dirty, writeBack, mem_req, mem_we;
    logic [0:0] LRU;
    logic [2:0] tag, dadoParaCPU, mem_wdata;
    logic [4:0] mem_addr;
`ifdef CACHE_STATS_EN
    logic [15:0] hitCount, missCount;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       hit;
        logic       valid;
        logic       lru;
        logic       dirty;
        logic       wb;
        logic [2:0] tag;
        logic [2:0] dado;
    } resp_t;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [2:0] wdata;
        logic [2:0] rdata;
    } mem_t;

    resp_t resp_q[$];
    mem_t  mem_q[$];

    memoria_cache_param dut (
        .clock(clock), .reset(reset), .req(req), .wren(wren), .data(data), .address(address),
        .ready(ready), .hit(hit), .valid(valid), .LRU(LRU), .dirty(dirty), .writeBack(writeBack),
        .tag(tag), .dadoParaCPU(dadoParaCPU), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .hitCount(hitCount), .missCount(missCount)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic exp_r(input logic h, input logic v, input logic l, input logic dt,
                         input logic w, input logic [2:0] t, input logic [2:0] x);
        resp_q.push_back('{h, v, l, dt, w, t, x});
    endtask

    task automatic exp_m(input logic we, input logic [4:0] a, input logic [2:0] wd, input logic [2:0] rd);
        mem_q.push_back('{we, a, wd, rd});
    endtask

    // Issue one access, serve memory with 'stall' wait cycles per phase, check the response.
    task automatic access(input logic wr, input logic [4:0] a, input logic [2:0] d,
                          input int stall, input logic exp_hit);
        int    cycles = 0;
        int    held   = 0;
        bit    done   = 1'b0;
        resp_t e;
        mem_t  m;
        @(negedge clock);
        req = 1'b1; wren = wr; address = a; data = d;
        @(negedge clock);
        req = 1'b0;
        while (!done && cycles < 200) begin
            mem_ack = 1'b0;
            if (ready) begin
                if (resp_q.size() == 0) begin
                    check_eq("resp_unexpected", ready, 0);
                end else begin
                    e = resp_q.pop_front();
                    check_eq("hit", hit, e.hit);
                    check_eq("valid", valid, e.valid);
                    check_eq("lru", LRU, e.lru);
                    check_eq("dirty", dirty, e.dirty);
                    check_eq("writeBack", writeBack, e.wb);
                    check_eq("tag", tag, e.tag);
                    check_eq("dado", dadoParaCPU, e.dado);
                    if (exp_hit) check_eq("hit_latency", cycles, 0);
                end
                done = 1'b1;
            end else begin
                if (mem_req) begin
                    if (mem_q.size() == 0) begin
                        check_eq("mem_req_unexpected", mem_req, 0);
                    end else begin
                        m = mem_q[0];
                        check_eq("mem_we", mem_we, m.we);
                        check_eq("mem_addr", mem_addr, m.addr);
                        if (m.we) check_eq("mem_wdata", mem_wdata, m.wdata);
                        if (held == stall) begin
                            mem_ack   = 1'b1;
                            mem_rdata = m.rdata;
                            void'(mem_q.pop_front());
                            held = 0;
                        end else begin
                            held++;
                        end
                    end
                end
                @(negedge clock);
                cycles++;
            end
        end
        mem_ack = 1'b0;
        if (!done) check_eq("ready_timeout", done, 1);
        check_eq("mem_ops_left", mem_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; wren = 1'b0; data = 3'd0; address = 5'd0;
        mem_ack = 1'b0; mem_rdata = 3'd0;
        repeat (3) @(negedge clock);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_lru", LRU, 0);
        check_eq("rst_dirty", dirty, 0);
        check_eq("rst_wb", writeBack, 0);
        check_eq("rst_tag", tag, 0);
        check_eq("rst_dado", dadoParaCPU, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;

        // Cold read miss, then hits and a dirty eviction in set 0.
        exp_m(1'b0, 5'd16, 3'd0, 3'd5); exp_r(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd5);
        access(1'b0, 5'd16, 3'd0, 0, 1'b0);
        exp_r(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd5);
        access(1'b0, 5'd16, 3'd0, 0, 1'b1);
        exp_r(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 3'd3);
        access(1'b1, 5'd16, 3'd3, 0, 1'b1);
        exp_m(1'b0, 5'd4, 3'd0, 3'd6); exp_r(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd6);
        access(1'b0, 5'd4, 3'd0, 0, 1'b0);
        exp_m(1'b1, 5'd16, 3'd3, 3'd0); exp_m(1'b0, 5'd8, 3'd0, 3'd2);
        exp_r(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 3'd2);
        access(1'b0, 5'd8, 3'd0, 1, 1'b0);
`ifdef CACHE_STATS_EN
        check_eq("hitCount", hitCount, 2);
        check_eq("missCount", missCount, 3);
`endif

        // Write misses in set 3: clean install, then install after a write-back.
        exp_r(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
        access(1'b1, 5'd3, 3'd7, 0, 1'b0);
        exp_r(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1);
        access(1'b1, 5'd7, 3'd1, 0, 1'b0);
        exp_m(1'b1, 5'd3, 3'd7, 3'd0); exp_r(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 3'd2);
        access(1'b1, 5'd11, 3'd2, 0, 1'b0);

        // Memory stall of 10 cycles during a fill.
        exp_m(1'b0, 5'd13, 3'd0, 3'd4); exp_r(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd4);
        access(1'b0, 5'd13, 3'd0, 10, 1'b0);

        // Way 1 of set 0 survived the eviction of way 0.
        exp_r(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd6);
        access(1'b0, 5'd4, 3'd0, 0, 1'b1);

        // Reset in the middle of a fill.
        @(negedge clock);
        req = 1'b1; wren = 1'b0; address = 5'd1;
        @(negedge clock);
        req = 1'b0;
        check_eq("midfill_mem_req", mem_req, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("reset_mem_req", mem_req, 0);
        check_eq("reset_ready", ready, 0);
        check_eq("reset_valid", valid, 0);
        exp_m(1'b0, 5'd16, 3'd0, 3'd6); exp_r(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd6);
        access(1'b0, 5'd16, 3'd0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
